// File: rtl/ws2811_frame_sequencer_pkg.sv
// Shared definitions for the WS2811 transmit sequencer: word width, default
// timing derived from the OSCH clock, FSM state encoding and a small helper.
package ws2811_frame_sequencer_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned OSCH_FREQ_HZ = 20_000_000;
  localparam int unsigned BIT_RATE_HZ  = 1_250_000;
  localparam int unsigned LATCH_GAP_US = 50;

  // One encoded bit per BIT_RATE_HZ period.
  localparam int unsigned DEF_BIT_PERIOD_CYCLES = OSCH_FREQ_HZ / BIT_RATE_HZ;
  // Latch gap rounded up to a power of two so it never falls short of 50 us.
  localparam int unsigned DEF_LATCH_CYCLES =
    1 << $clog2((OSCH_FREQ_HZ / 1_000_000) * LATCH_GAP_US);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_WORD = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_LATCH     = 2'd3
  } seq_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ws2811_frame_sequencer_if.sv
// Word handshake between the local requester (master) and the sequencer (slave).
interface ws2811_frame_sequencer_if;
  import ws2811_frame_sequencer_pkg::*;

  logic              start;
  logic [WORD_W-1:0] wordData;
  logic              wordValid;
  logic              wordLast;
  logic              wordReady;

  modport master (output start, output wordData, output wordValid,
                  output wordLast, input wordReady);
  modport slave  (input start, input wordData, input wordValid,
                  input wordLast, output wordReady);
endinterface

// File: rtl/ws2811_frame_sequencer_bit_timer.sv
// Bit-period timer. Internally a down-counter: a remaining count of
// BIT_PERIOD_CYCLES-1 corresponds to elapsed cycle 0 of the period, so the
// strobe (elapsed 1) and the wrap (elapsed BIT_PERIOD_CYCLES-1) are
// terminal-count compares. Shared by the shift phase and the word timeout.
module ws2811_bit_timer #(
  parameter int unsigned BIT_PERIOD_CYCLES = 16
) (
  input  logic masterClk,
  input  logic nReset,
  input  logic clear_i,
  input  logic run_i,
  output logic strobe_o,
  output logic wrap_o
);

  localparam logic [7:0] LOAD      = 8'(BIT_PERIOD_CYCLES - 1);
  localparam logic [7:0] STROBE_AT = 8'(BIT_PERIOD_CYCLES - 2);

  logic [7:0] remain_q, remain_d;

  // Next remaining count: restart on clear, reload after the terminal count.
  always_comb begin
    remain_d = remain_q;
    if (clear_i) begin
      remain_d = LOAD;
    end else if (run_i) begin
      remain_d = (remain_q == 8'd0) ? LOAD : remain_q - 8'd1;
    end
  end

  // Counter register; reset value means "elapsed cycle 0".
  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset) remain_q <= LOAD;
    else         remain_q <= remain_d;
  end

  assign strobe_o = run_i && (remain_q == STROBE_AT);
  assign wrap_o   = run_i && (remain_q == 8'd0);

endmodule

// File: rtl/ws2811_frame_sequencer.sv
// Transmit-side sequencer for the WS2811 encoder: takes 32-bit words over a
// valid/ready handshake, emits them MSB-first as dataOut/dataClk strobes and
// closes every frame with the latch gap.
//
// state        | meaning
// ST_IDLE      | waiting for start; line idle
// ST_WAIT_WORD | wordReady high; times out after one bit period (underrun)
// ST_SHIFT     | one bit per bit period; next word may load back-to-back
// ST_LATCH     | line held idle for LATCH_CYCLES; done on the final cycle
module ws2811_frame_sequencer
  import ws2811_frame_sequencer_pkg::*;
#(
  parameter int unsigned BIT_PERIOD_CYCLES = DEF_BIT_PERIOD_CYCLES,
  parameter int unsigned LATCH_CYCLES      = DEF_LATCH_CYCLES
) (
  input  logic                            masterClk,
  input  logic                            nReset,
  ws2811_frame_sequencer_if.slave         req,
  output logic                            dataOut,
  output logic                            dataClk,
  output logic                            busy,
  output logic                            done,
  output logic                            underrun,
  output logic [7:0]                      wordCount
);

  localparam logic [15:0] LATCH_LOAD = 16'(LATCH_CYCLES - 1);
  localparam logic [4:0]  LAST_BIT   = 5'(WORD_W - 1);

  seq_state_e        state_q;
  logic [WORD_W-1:0] shift_q;
  logic              last_q;
  logic [4:0]        bit_cnt_q;
  logic [7:0]        word_cnt_q;
  logic              underrun_q;
  logic              busy_q;
  logic              done_q;
  logic [15:0]       latch_cnt_q;

  logic tmr_strobe, tmr_wrap, tmr_run, tmr_clear;
  logic last_bit_wrap, accept;

  assign tmr_run       = (state_q == ST_WAIT_WORD) || (state_q == ST_SHIFT);
  assign last_bit_wrap = (state_q == ST_SHIFT) && tmr_wrap && (bit_cnt_q == LAST_BIT);
  assign req.wordReady = (state_q == ST_WAIT_WORD) || (last_bit_wrap && !last_q);
  assign accept        = req.wordReady && req.wordValid;
  // Every entry into WAIT_WORD or a new word starts the bit period from zero.
  assign tmr_clear     = (state_q == ST_IDLE) || accept || last_bit_wrap;

  ws2811_bit_timer #(.BIT_PERIOD_CYCLES(BIT_PERIOD_CYCLES)) u_bit_timer (
    .masterClk (masterClk),
    .nReset    (nReset),
    .clear_i   (tmr_clear),
    .run_i     (tmr_run),
    .strobe_o  (tmr_strobe),
    .wrap_o    (tmr_wrap)
  );

  // Frame sequencing: word loading, bit shifting, underrun and latch gap.
  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      last_q      <= 1'b0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      latch_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req.start) begin
            state_q    <= ST_WAIT_WORD;
            busy_q     <= 1'b1;
            underrun_q <= 1'b0;
            word_cnt_q <= '0;
          end
        end
        ST_WAIT_WORD: begin
          if (req.wordValid) begin
            shift_q    <= req.wordData;
            last_q     <= req.wordLast;
            word_cnt_q <= sat_inc8(word_cnt_q);
            bit_cnt_q  <= '0;
            state_q    <= ST_SHIFT;
          end else if (tmr_wrap) begin
            underrun_q  <= 1'b1;
            latch_cnt_q <= LATCH_LOAD;
            state_q     <= ST_LATCH;
          end
        end
        ST_SHIFT: begin
          if (tmr_wrap) begin
            shift_q   <= {shift_q[WORD_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == LAST_BIT) begin
              if (last_q) begin
                latch_cnt_q <= LATCH_LOAD;
                state_q     <= ST_LATCH;
              end else if (req.wordValid) begin
                // Back-to-back word: the load overrides the shift above.
                shift_q    <= req.wordData;
                last_q     <= req.wordLast;
                word_cnt_q <= sat_inc8(word_cnt_q);
                bit_cnt_q  <= '0;
              end else begin
                state_q <= ST_WAIT_WORD;
              end
            end
          end
        end
        ST_LATCH: begin
          if (latch_cnt_q == 16'd0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            latch_cnt_q <= latch_cnt_q - 16'd1;
            done_q      <= (latch_cnt_q == 16'd1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dataOut   = (state_q == ST_SHIFT) && shift_q[WORD_W-1];
  assign dataClk   = (state_q == ST_SHIFT) && tmr_strobe;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underrun  = underrun_q;
  assign wordCount = word_cnt_q;

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Bench for ws2811_frame_sequencer: directed frames, a timestamp-based model
// checked every cycle, a bit-level decoder and literal per-frame expectations.
module tb_ws2811_frame_sequencer;

  localparam int P = 16;
  localparam int L = 64;
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_SHIFT = 2, PH_LATCH = 3;

  logic       masterClk = 1'b0;
  logic       nReset;
  logic       dataOut, dataClk, busy, done, underrun;
  logic [7:0] wordCount;

  ws2811_frame_sequencer_if u_if ();

  ws2811_frame_sequencer #(.BIT_PERIOD_CYCLES(P), .LATCH_CYCLES(L)) dut (
    .masterClk (masterClk),
    .nReset    (nReset),
    .req       (u_if),
    .dataOut   (dataOut),
    .dataClk   (dataClk),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun),
    .wordCount (wordCount)
  );

  always #5 masterClk = ~masterClk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit abort   = 1'b0;

  always @(posedge masterClk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // model state: phase plus the cycle the phase began
  int          m_phase = PH_IDLE;
  int          m_t0    = 0;
  logic [31:0] m_word  = '0;
  bit          m_last  = 1'b0;
  int          m_cnt   = 0;
  bit          m_und   = 1'b0;

  // per-frame statistics and decoded words
  int          strobe_n, first_strobe_cyc, last_strobe_cyc, min_gap, max_gap;
  int          done_n, done_cyc, start_cyc, hi_n, bit_n;
  logic [31:0] dec;
  logic [31:0] cap[$];

  task automatic clear_stats();
    strobe_n = 0; first_strobe_cyc = 0; last_strobe_cyc = 0;
    min_gap = 1000000; max_gap = 0; done_n = 0; done_cyc = 0; hi_n = 0;
    bit_n = 0; dec = '0; cap.delete();
  endtask

  always @(negedge masterClk) begin : monitor
    int e;
    bit x_busy, x_ready, x_out, x_clk, x_done;
    if (cyc > 0) begin
      if (!nReset) begin
        chk("reset_outputs", {dataOut, dataClk, busy, done, underrun, u_if.wordReady, wordCount}, 0);
        m_phase = PH_IDLE; m_und = 0; m_cnt = 0; bit_n = 0;
      end else begin
        e       = cyc - m_t0;
        x_busy  = (m_phase != PH_IDLE);
        x_ready = (m_phase == PH_WAIT) || (m_phase == PH_SHIFT && e == 32*P-1 && !m_last);
        x_out   = (m_phase == PH_SHIFT) ? m_word[31 - e/P] : 1'b0;
        x_clk   = (m_phase == PH_SHIFT) && (e % P == 1);
        x_done  = (m_phase == PH_LATCH) && (e == L-1);
        chk("busy", busy, x_busy);
        chk("wordReady", u_if.wordReady, x_ready);
        chk("dataOut", dataOut, x_out);
        chk("dataClk", dataClk, x_clk);
        chk("done", done, x_done);
        chk("underrun", underrun, m_und);
        chk("wordCount", wordCount, m_cnt);

        if (dataClk) begin
          if (strobe_n > 0) begin
            if (cyc - last_strobe_cyc < min_gap) min_gap = cyc - last_strobe_cyc;
            if (cyc - last_strobe_cyc > max_gap) max_gap = cyc - last_strobe_cyc;
          end else begin
            first_strobe_cyc = cyc;
          end
          last_strobe_cyc = cyc;
          strobe_n++;
          dec = {dec[30:0], dataOut};
          bit_n++;
          if (bit_n == 32) begin
            cap.push_back(dec);
            bit_n = 0;
          end
        end
        if (dataOut) hi_n++;
        if (done) begin done_n++; done_cyc = cyc; end

        case (m_phase)
          PH_IDLE: if (u_if.start) begin
            m_phase = PH_WAIT; m_t0 = cyc + 1; m_und = 0; m_cnt = 0; start_cyc = cyc;
          end
          PH_WAIT: if (u_if.wordValid) begin
            m_phase = PH_SHIFT; m_t0 = cyc + 1; m_word = u_if.wordData;
            m_last = u_if.wordLast; if (m_cnt < 255) m_cnt++;
          end else if (e == P-1) begin
            m_phase = PH_LATCH; m_t0 = cyc + 1; m_und = 1;
          end
          PH_SHIFT: if (e == 32*P-1) begin
            if (m_last) begin
              m_phase = PH_LATCH; m_t0 = cyc + 1;
            end else if (u_if.wordValid) begin
              m_t0 = cyc + 1; m_word = u_if.wordData;
              m_last = u_if.wordLast; if (m_cnt < 255) m_cnt++;
            end else begin
              m_phase = PH_WAIT; m_t0 = cyc + 1;
            end
          end
          default: if (e == L-1) m_phase = PH_IDLE;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge masterClk);
    #1;
  endtask

  task automatic pulse_start();
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit last, input int pre, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < pre && !abort; k++) tick();
    if (!abort) begin
      u_if.wordData = w; u_if.wordLast = last; u_if.wordValid = 1'b1;
      for (int k = 0; k < 600 && !ok && !abort; k++) begin
        @(negedge masterClk);
        if (u_if.wordReady) ok = 1'b1;
        tick();
      end
    end
    u_if.wordValid = 1'b0;
    u_if.wordLast  = 1'b0;
  endtask

  logic [31:0] fw[8];
  int          fd[8];

  task automatic run_frame(input int n, output int n_acc);
    bit ok;
    n_acc = 0;
    pulse_start();
    for (int i = 0; i < n && !abort; i++) begin
      send_word(fw[i], (i == n-1), fd[i], ok);
      if (ok) n_acc++;
    end
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 3000 && done_n == 0; k++) tick();
    chk(name, done_n, 1);
    tick();
    tick();
  endtask

  int n_acc;

  initial begin
    nReset = 1'b0;
    u_if.start = 1'b0; u_if.wordData = '0; u_if.wordValid = 1'b0; u_if.wordLast = 1'b0;
    for (int i = 0; i < 8; i++) begin fw[i] = '0; fd[i] = 0; end
    clear_stats();
    repeat (3) tick();
    chk("reset_state", {dataOut, dataClk, busy, done, underrun, u_if.wordReady, wordCount}, 0);
    nReset = 1'b1;
    tick(); tick();

    // four back-to-back words
    clear_stats();
    fw[0] = 32'h55AA00FF; fw[1] = 32'hF00F1234; fw[2] = 32'h00000000; fw[3] = 32'hFFFFFFFF;
    run_frame(4, n_acc);
    wait_done("t1_done_count");
    chk("t1_accepted", n_acc, 4);
    chk("t1_strobes", strobe_n, 128);
    chk("t1_min_gap", min_gap, 16);
    chk("t1_max_gap", max_gap, 16);
    chk("t1_first_strobe_latency", first_strobe_cyc - start_cyc, 3);
    chk("t1_frame_time", done_cyc - start_cyc, 2113);
    chk("t1_word_count", wordCount, 4);
    chk("t1_underrun", underrun, 0);
    chk("t1_cap_size", cap.size(), 4);
    for (int i = 0; i < cap.size() && i < 4; i++) chk("t1_cap_word", cap[i], fw[i]);

    // single word with only bits 31 and 0 set
    clear_stats();
    fw[0] = 32'h80000001;
    run_frame(1, n_acc);
    wait_done("t2_done_count");
    chk("t2_strobes", strobe_n, 32);
    chk("t2_high_cycles", hi_n, 32);
    chk("t2_frame_time", done_cyc - start_cyc, 577);
    chk("t2_cap_size", cap.size(), 1);
    if (cap.size() == 1) chk("t2_cap_word", cap[0], 32'h80000001);

    // second word withheld past the timeout
    clear_stats();
    fw[0] = 32'h12345678; fw[1] = 32'hCAFEF00D; fd[0] = 0; fd[1] = 552;
    run_frame(2, n_acc);
    wait_done("t3_done_count");
    chk("t3_accepted", n_acc, 1);
    chk("t3_underrun", underrun, 1);
    chk("t3_word_count", wordCount, 1);
    chk("t3_strobes", strobe_n, 32);

    // second word 8 cycles late, within the timeout
    clear_stats();
    fw[0] = 32'hA5A50F0F; fw[1] = 32'h01234567; fd[0] = 0; fd[1] = 520;
    run_frame(2, n_acc);
    chk("t4_underrun_cleared", underrun, 0);
    wait_done("t4_done_count");
    chk("t4_accepted", n_acc, 2);
    chk("t4_underrun", underrun, 0);
    chk("t4_min_gap", min_gap, 16);
    chk("t4_gap_in_range", (max_gap > 16) && (max_gap <= 32), 1);
    chk("t4_word_count", wordCount, 2);
    chk("t4_cap_size", cap.size(), 2);
    for (int i = 0; i < cap.size() && i < 2; i++) chk("t4_cap_word", cap[i], fw[i]);

    // start pulses during SHIFT and LATCH are ignored
    clear_stats();
    fw[0] = 32'hDEADBEEF; fw[1] = 32'h0F1E2D3C; fd[0] = 0; fd[1] = 0;
    fork
      run_frame(2, n_acc);
      begin
        repeat (200) tick();
        u_if.start = 1'b1; tick(); u_if.start = 1'b0;
        repeat (838) tick();
        chk("t5_busy_at_latch_start", busy, 1);
        u_if.start = 1'b1; tick(); u_if.start = 1'b0;
      end
    join
    wait_done("t5_done_count");
    chk("t5_word_count", wordCount, 2);
    chk("t5_frame_time", done_cyc - start_cyc, 1089);
    chk("t5_strobes", strobe_n, 64);
    chk("t5_cap_size", cap.size(), 2);
    for (int i = 0; i < cap.size() && i < 2; i++) chk("t5_cap_word", cap[i], fw[i]);

    // reset in the middle of word 2
    clear_stats();
    fw[0] = 32'h11112222; fw[1] = 32'h33334444; fw[2] = 32'h55556666;
    fork
      run_frame(3, n_acc);
      begin
        repeat (700) tick();
        #2;
        nReset = 1'b0;
        #1;
        chk("t6_async_reset_outputs",
            {dataOut, dataClk, busy, done, underrun, u_if.wordReady, wordCount}, 0);
        abort = 1'b1;
      end
    join
    u_if.start = 1'b0; u_if.wordValid = 1'b0; u_if.wordLast = 1'b0;
    abort = 1'b0;
    tick(); tick();
    nReset = 1'b1;
    tick();

    // fresh frame after reset
    clear_stats();
    fw[0] = 32'h3C3CC3C3;
    run_frame(1, n_acc);
    chk("t7_word_count_restart", wordCount, 1);
    wait_done("t7_done_count");
    chk("t7_frame_time", done_cyc - start_cyc, 577);
    chk("t7_cap_size", cap.size(), 1);
    if (cap.size() == 1) chk("t7_cap_word", cap[0], 32'h3C3CC3C3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
